// File: rtl/dmem_dma_arbiter.sv
// Shares the single-port dmem BRAM between the CPU data port and a word-copy DMA engine.
// The CPU wins every conflict until the DMA has been denied STARVE_LIMIT times in a row.
module dmem_dma_arbiter #(
  parameter int ADDR_WIDTH   = 14,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cpu_req,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [3:0]            cpu_wr_mask,
  input  logic [31:0]           cpu_din,
  output logic                  cpu_stall,
  output logic [31:0]           cpu_dout,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_din,
  output logic [3:0]            mem_we,
  input  logic [31:0]           mem_dout,
  input  logic                  cfg_wren,
  input  logic [1:0]            cfg_sel,
  input  logic [31:0]           cfg_wdata,
  output logic                  dma_busy,
  output logic                  dma_done
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);
  localparam logic [ADDR_WIDTH:0] LEN_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

  typedef enum logic [1:0] {S_IDLE, S_RD, S_CAP, S_WR} state_t;

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] src_reg, dst_reg;
  logic [ADDR_WIDTH:0]   len_reg;
  logic [ADDR_WIDTH-1:0] wsrc, wdst;
  logic [ADDR_WIDTH:0]   wrem;
  logic [31:0]           buf_p1;
  logic [CNT_W-1:0]      starve_cnt;

  logic cfg_ctrl, start, start_go, start_empty, clr_done;
  logic dma_req, forced, cpu_gnt, dma_gnt, wr_gnt, wr_last;
  logic cfg_unused;

  // Word addresses wrap naturally at the port width.
  function automatic logic [ADDR_WIDTH-1:0] addr_inc(input logic [ADDR_WIDTH-1:0] a);
    return a + 1'b1;
  endfunction

  assign cfg_unused  = ^cfg_wdata[31:ADDR_WIDTH+1];

  assign cfg_ctrl    = cfg_wren && (cfg_sel == 2'd3);
  assign start       = cfg_ctrl && cfg_wdata[0] && (state == S_IDLE);
  assign start_go    = start && (len_reg != '0);
  assign start_empty = start && (len_reg == '0);
  assign clr_done    = cfg_ctrl && cfg_wdata[1];

  assign dma_req   = (state == S_RD) || (state == S_WR);
  assign forced    = (starve_cnt == LIMIT);
  assign cpu_gnt   = cpu_req && !forced;
  assign dma_gnt   = dma_req && (!cpu_req || forced);
  assign cpu_stall = cpu_req && forced;
  assign wr_gnt    = (state == S_WR) && dma_gnt;
  assign wr_last   = wr_gnt && (wrem == LEN_ONE);

  assign dma_busy  = (state != S_IDLE);
  assign cpu_dout  = mem_dout;

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // FSM next state
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start_go) state_nxt = S_RD;
      S_RD:    if (dma_gnt) state_nxt = S_CAP;
      S_CAP:   state_nxt = S_WR;
      S_WR:    if (dma_gnt) state_nxt = (wrem == LEN_ONE) ? S_IDLE : S_RD;
      default: state_nxt = S_IDLE;
    endcase
  end

  // FSM outputs: BRAM port mux
  always_comb begin
    mem_addr = cpu_addr;
    mem_din  = cpu_din;
    mem_we   = 4'h0;
    if (dma_gnt) begin
      mem_addr = (state == S_RD) ? wsrc : wdst;
      mem_din  = buf_p1;
      mem_we   = (state == S_WR) ? 4'hF : 4'h0;
    end else if (cpu_gnt) begin
      mem_we   = cpu_wr_mask;
    end
  end

  // Control state: software registers, starvation counter, done flag
  always_ff @(posedge clk) begin
    if (rst) begin
      src_reg    <= '0;
      dst_reg    <= '0;
      len_reg    <= '0;
      starve_cnt <= '0;
      dma_done   <= 1'b0;
    end else begin
      if (cfg_wren && (state == S_IDLE)) begin
        case (cfg_sel)
          2'd0:    src_reg <= cfg_wdata[ADDR_WIDTH-1:0];
          2'd1:    dst_reg <= cfg_wdata[ADDR_WIDTH-1:0];
          2'd2:    len_reg <= cfg_wdata[ADDR_WIDTH:0];
          default: ;
        endcase
      end
      if (dma_req && !dma_gnt) starve_cnt <= starve_cnt + 1'b1;
      else                     starve_cnt <= '0;
      if (start_empty || wr_last)  dma_done <= 1'b1;
      else if (clr_done || start_go) dma_done <= 1'b0;
    end
  end

  // Datapath: working copies and the captured read word
  always_ff @(posedge clk) begin
    if (start_go) begin
      wsrc <= src_reg;
      wdst <= dst_reg;
      wrem <= len_reg;
    end else if (wr_gnt) begin
      wsrc <= addr_inc(wsrc);
      wdst <= addr_inc(wdst);
      wrem <= wrem - 1'b1;
    end
    if (state == S_CAP) buf_p1 <= mem_dout;
  end

endmodule
